chnl_rx_unpacker: RTL and testbench
===================================

# chnl_rx_unpacker

Receive-side user stage for one RIFFA channel. It accepts a host-to-FPGA transfer on the channel RX interface and unpacks each C_PCI_DATA_WIDTH beat into a 32-bit word stream with valid/ready handshaking and a last-word marker. It discards pad words beyond CHNL_RX_LEN and reports completion or abort. It sits between the RIFFA channel RX port and user logic, such as a word-oriented processing core or a TX-side packer.

## Interface
- C_PCI_DATA_WIDTH, 128, RX beat width; legal values 32/64/128/256; W = C_PCI_DATA_WIDTH/32 words per beat.
- CLK  in  1  clock for all logic; forwarded unchanged to CHNL_RX_CLK.
- RST  in  1  reset, asynchronous, active-high.
- CHNL_RX_CLK  out  1  equals CLK.
- CHNL_RX  in  1  transfer request; held high by RIFFA for the transfer.
- CHNL_RX_ACK  out  1  one-cycle acknowledge.
- CHNL_RX_LAST  in  1  last transfer of a sequence; latched.
- CHNL_RX_LEN  in  32  transfer length in 32-bit words; latched.
- CHNL_RX_OFF  in  31  offset; latched.
- CHNL_RX_DATA  in  C_PCI_DATA_WIDTH  beat data; word 0 is in bits [31:0].
- CHNL_RX_DATA_VALID  in  1  beat valid.
- CHNL_RX_DATA_REN  out  1  beat accept.
- WORD_DATA  out  32  current word.
- WORD_VALID  out  1  WORD_DATA is valid.
- WORD_READY  in  1  consumer accepts the word.
- WORD_LAST  out  1  qualifies the final word of the transfer.
- XFER_LEN  out  32  latched length.
- XFER_OFF  out  31  latched offset.
- XFER_SEQ_LAST  out  1  latched CHNL_RX_LAST.
- XFER_DONE  out  1  one-cycle pulse at transfer end.
- XFER_ABORT  out  1  qualifies XFER_DONE; high when the transfer ended early.
- STAT_XFERS  out  32  completed-transfer count (see Configuration).
- STAT_WORDS  out  32  delivered-word count (see Configuration).

## Operation
- States: IDLE, ACK, RECV, DONE.
- IDLE:
  - On CHNL_RX=1, latch LEN, OFF and LAST.
  - Clear rRcvd, rSent and idx, then go to ACK.
- ACK:
  - CHNL_RX_ACK=1 for exactly this cycle.
  - If LEN==0, go to DONE with XFER_ABORT=0; otherwise go to RECV.
- RECV uses a one-beat holding buffer (bufValid, idx in 0..W-1).
  - CHNL_RX_DATA_REN = RECV && rRcvd<LEN && (!bufValid || (WORD_VALID && WORD_READY && idx==W-1 && !WORD_LAST)).
  - On VALID&&REN: load the buffer, set bufValid, set idx=0, and add W to rRcvd (32-bit add; LEN ≤ 2^32−W is guaranteed).
  - WORD_DATA = buf[idx*32 +: 32]; WORD_VALID = bufValid.
  - WORD_LAST = (rSent == LEN−1).
  - On word handshake: rSent++ and idx++.
    - At idx==W−1 the buffer empties unless it is reloaded in the same cycle.
    - On WORD_LAST the buffer is cleared, remaining pad words are dropped, and the block goes to DONE.
  - Abort: CHNL_RX low while rRcvd<LEN and !bufValid: go to DONE with XFER_ABORT=1 and no WORD_LAST.
  - Beats already accepted are always fully drained before abort is evaluated.
- DONE:
  - XFER_DONE=1 for one cycle, then go to IDLE.
  - A new CHNL_RX is not sampled until IDLE, so back-to-back transfers have ≥1 idle cycle.
- RST mid-transfer: the block returns to IDLE immediately; buffered data is lost; no DONE pulse.

## Timing
- Reset values:
  - CHNL_RX_ACK=0, CHNL_RX_DATA_REN=0, WORD_VALID=0, WORD_LAST=0, WORD_DATA=0.
  - XFER_LEN=0, XFER_OFF=0, XFER_SEQ_LAST=0, XFER_DONE=0, XFER_ABORT=0.
  - STAT_*=0.
- Latency:
  - CHNL_RX rising in cycle N gives ACK in N+1.
  - A beat accepted at edge M gives WORD_VALID from M+1.
- Throughput:
  - 1 word per cycle with WORD_READY held high and VALID continuous; no bubble between beats.
- Handshake: WORD_DATA and WORD_LAST are stable while WORD_VALID && !WORD_READY.
- Combinational paths: REN depends combinationally on WORD_READY. There is no other input-to-output combinational path.

## Configuration
- CHNL_RX_UNPACK_STATS_EN defined:
  - STAT_XFERS increments on each non-abort XFER_DONE.
  - STAT_WORDS increments on each word handshake.
  - Both wrap modulo 2^32 and are reset by RST.
- Not defined: STAT_XFERS and STAT_WORDS are tied to 0; no counter logic is built.

## Test plan
- W=4, LEN=8, two beats, READY=1 -> words 0..7 on consecutive cycles; WORD_LAST on word 7; REN high on both beat cycles with no bubble; XFER_DONE one cycle later with ABORT=0.
- LEN=5, two beats (8 words supplied) -> exactly 5 words delivered, LAST on the 5th, pad words 5..7 never visible; STAT_WORDS=5 with the macro defined.
- LEN=8, READY toggling 1/0 every cycle -> each word held stable while READY=0; REN asserted only when the buffer drains; 8 words in order.
- LEN=0 -> ACK for one cycle, no REN, no WORD_VALID, XFER_DONE with ABORT=0 two cycles after CHNL_RX.
- LEN=12, CHNL_RX dropped after the first beat is drained -> 4 words, no WORD_LAST, XFER_DONE with ABORT=1; STAT_XFERS unchanged.
- RST asserted mid-RECV with a buffered beat -> all outputs take reset values immediately; a next transfer with LEN=4 completes normally.

Source files
------------

// File: rtl/chnl_rx_unpacker_if.sv
// Channel RX bundle for chnl_rx_unpacker: the RIFFA RX port, the 32-bit word stream,
// transfer status and statistics. The slave modport is the unpacker's view.
interface chnl_rx_unpacker_if #(
  parameter int C_PCI_DATA_WIDTH = 128
);
  logic                        CHNL_RX_CLK;
  logic                        CHNL_RX;
  logic                        CHNL_RX_ACK;
  logic                        CHNL_RX_LAST;
  logic [31:0]                 CHNL_RX_LEN;
  logic [30:0]                 CHNL_RX_OFF;
  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA;
  logic                        CHNL_RX_DATA_VALID;
  logic                        CHNL_RX_DATA_REN;

  logic [31:0]                 WORD_DATA;
  logic                        WORD_VALID;
  logic                        WORD_READY;
  logic                        WORD_LAST;

  logic [31:0]                 XFER_LEN;
  logic [30:0]                 XFER_OFF;
  logic                        XFER_SEQ_LAST;
  logic                        XFER_DONE;
  logic                        XFER_ABORT;
  logic [31:0]                 STAT_XFERS;
  logic [31:0]                 STAT_WORDS;

  modport slave (
    output CHNL_RX_CLK,
    input  CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF,
    input  CHNL_RX_DATA, CHNL_RX_DATA_VALID,
    output CHNL_RX_ACK, CHNL_RX_DATA_REN,
    output WORD_DATA, WORD_VALID, WORD_LAST,
    input  WORD_READY,
    output XFER_LEN, XFER_OFF, XFER_SEQ_LAST, XFER_DONE, XFER_ABORT,
    output STAT_XFERS, STAT_WORDS
  );

  modport master (
    input  CHNL_RX_CLK,
    output CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF,
    output CHNL_RX_DATA, CHNL_RX_DATA_VALID,
    input  CHNL_RX_ACK, CHNL_RX_DATA_REN,
    input  WORD_DATA, WORD_VALID, WORD_LAST,
    output WORD_READY,
    input  XFER_LEN, XFER_OFF, XFER_SEQ_LAST, XFER_DONE, XFER_ABORT,
    input  STAT_XFERS, STAT_WORDS
  );
endinterface

// File: rtl/chnl_rx_unpacker.sv
// RIFFA channel RX unpacker: splits each RX beat into 32-bit words, drops pad words past
// CHNL_RX_LEN, reports done/abort. Define CHNL_RX_UNPACK_STATS_EN to build the STAT_* counters.
module chnl_rx_unpacker #(
  parameter int C_PCI_DATA_WIDTH = 128
) (
  input  logic               CLK,
  input  logic               RST,
  chnl_rx_unpacker_if.slave  chnl
);

  localparam int W = C_PCI_DATA_WIDTH / 32;
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_RECV,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [31:0]           r_len;
  logic [30:0]           r_off;
  logic                  r_seq_last;
  logic [31:0]           r_rcvd;
  logic [31:0]           r_sent;
  logic                  r_abort;

  logic [W-1:0][31:0]    r_buf;
  logic                  r_buf_valid;
  logic [IDX_W-1:0]      r_idx;

  logic                  w_in_recv;
  logic                  w_word_last;
  logic                  w_word_hs;
  logic                  w_more;
  logic                  w_ren;
  logic                  w_load;
  logic                  w_abort;
  logic                  w_ack;
  logic                  w_done;

  assign w_in_recv   = (r_state == S_RECV);
  assign w_word_last = r_buf_valid && (r_sent == (r_len - 32'd1));
  assign w_word_hs   = r_buf_valid && chnl.WORD_READY;
  assign w_more      = (r_rcvd < r_len);

  // A new beat is taken into an empty buffer, or into one whose final word leaves this cycle.
  assign w_ren  = w_in_recv && w_more &&
                  (!r_buf_valid || (w_word_hs && (r_idx == IDX_LAST) && !w_word_last));
  assign w_load = w_ren && chnl.CHNL_RX_DATA_VALID;

  // Abort only once the buffer is empty; a beat arriving in the same cycle is still taken.
  assign w_abort = w_in_recv && !chnl.CHNL_RX && w_more && !r_buf_valid && !w_load;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_next = r_state;
    w_ack  = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (chnl.CHNL_RX) w_next = S_ACK;
      end
      S_ACK: begin
        w_ack  = 1'b1;
        w_next = (r_len == 32'd0) ? S_DONE : S_RECV;
      end
      S_RECV: begin
        if ((w_word_hs && w_word_last) || w_abort) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_len       <= '0;
      r_off       <= '0;
      r_seq_last  <= 1'b0;
      r_rcvd      <= '0;
      r_sent      <= '0;
      r_abort     <= 1'b0;
      // NOTE: the beat buffer is reset too, because WORD_DATA must read zero out of reset.
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
      r_idx       <= '0;
    end else begin
      if ((r_state == S_IDLE) && chnl.CHNL_RX) begin
        r_len      <= chnl.CHNL_RX_LEN;
        r_off      <= chnl.CHNL_RX_OFF;
        r_seq_last <= chnl.CHNL_RX_LAST;
        r_rcvd     <= '0;
        r_sent     <= '0;
        r_idx      <= '0;
        r_abort    <= 1'b0;
      end

      if (w_in_recv) begin
        if (w_abort) r_abort <= 1'b1;
        if (w_word_hs) r_sent <= r_sent + 32'd1;

        if (w_word_hs && w_word_last) begin
          r_buf_valid <= 1'b0;
          r_idx       <= '0;
        end else if (w_load) begin
          r_buf       <= chnl.CHNL_RX_DATA;
          r_buf_valid <= 1'b1;
          r_idx       <= '0;
          r_rcvd      <= r_rcvd + 32'(W);
        end else if (w_word_hs) begin
          if (r_idx == IDX_LAST) begin
            r_buf_valid <= 1'b0;
            r_idx       <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
      end
    end
  end

`ifdef CHNL_RX_UNPACK_STATS_EN
  logic [31:0] r_stat_xfers;
  logic [31:0] r_stat_words;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stat_xfers <= '0;
      r_stat_words <= '0;
    end else begin
      if (w_word_hs) r_stat_words <= r_stat_words + 32'd1;
      if (w_done && !r_abort) r_stat_xfers <= r_stat_xfers + 32'd1;
    end
  end

  assign chnl.STAT_XFERS = r_stat_xfers;
  assign chnl.STAT_WORDS = r_stat_words;
`else
  assign chnl.STAT_XFERS = '0;
  assign chnl.STAT_WORDS = '0;
`endif

  assign chnl.CHNL_RX_CLK      = CLK;
  assign chnl.CHNL_RX_ACK      = w_ack;
  assign chnl.CHNL_RX_DATA_REN = w_ren;

  assign chnl.WORD_DATA  = r_buf[r_idx];
  assign chnl.WORD_VALID = r_buf_valid;
  assign chnl.WORD_LAST  = w_word_last;

  assign chnl.XFER_LEN      = r_len;
  assign chnl.XFER_OFF      = r_off;
  assign chnl.XFER_SEQ_LAST = r_seq_last;
  assign chnl.XFER_DONE     = w_done;
  assign chnl.XFER_ABORT    = w_done && r_abort;

endmodule

// File: tb/tb_chnl_rx_unpacker.sv
// Self-checking bench for chnl_rx_unpacker (W=4): table of transfers plus hand-written
// reset sequences; honours CHNL_RX_UNPACK_STATS_EN for the STAT_* expectations.
module tb_chnl_rx_unpacker;

  localparam int DW = 128;
  localparam int W  = DW / 32;

`ifdef CHNL_RX_UNPACK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  chnl_rx_unpacker_if #(.C_PCI_DATA_WIDTH(DW)) bus ();

  chnl_rx_unpacker #(.C_PCI_DATA_WIDTH(DW)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .chnl (bus)
  );

  typedef struct {
    logic [31:0] len;
    logic [30:0] off;
    logic        seq_last;
    int          beats;      // beats the source offers
    bit          toggle;     // WORD_READY alternates 1/0
    int          exp_words;
    bit          exp_abort;
    int          exp_done;   // cycle of XFER_DONE after CHNL_RX rises, -1 = not checked
  } vec_t;

  vec_t tbl [7];

  int checks   = 0;
  int failures = 0;
  int tot_xfers = 0;
  int tot_words = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_word(input int seq, input int b, input int k);
    return {8'(seq), 8'(b), 8'(k), 8'hC3};
  endfunction

  function automatic logic [DW-1:0] beat_data(input int seq, input int b);
    logic [DW-1:0] d;
    for (int k = 0; k < W; k++) d[k*32 +: 32] = beat_word(seq, b, k);
    return d;
  endfunction

  task automatic drive_idle();
    bus.CHNL_RX            = 1'b0;
    bus.CHNL_RX_LAST       = 1'b0;
    bus.CHNL_RX_LEN        = '0;
    bus.CHNL_RX_OFF        = '0;
    bus.CHNL_RX_DATA       = '0;
    bus.CHNL_RX_DATA_VALID = 1'b0;
    bus.WORD_READY         = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   bus.CHNL_RX_ACK, 1'b0);
    check({tag, "_ren"},   bus.CHNL_RX_DATA_REN, 1'b0);
    check({tag, "_valid"}, bus.WORD_VALID, 1'b0);
    check({tag, "_last"},  bus.WORD_LAST, 1'b0);
    check({tag, "_data"},  bus.WORD_DATA, 32'd0);
    check({tag, "_len"},   bus.XFER_LEN, 32'd0);
    check({tag, "_off"},   bus.XFER_OFF, 31'd0);
    check({tag, "_seql"},  bus.XFER_SEQ_LAST, 1'b0);
    check({tag, "_done"},  bus.XFER_DONE, 1'b0);
    check({tag, "_abort"}, bus.XFER_ABORT, 1'b0);
    check({tag, "_sx"},    bus.STAT_XFERS, 32'd0);
    check({tag, "_sw"},    bus.STAT_WORDS, 32'd0);
  endtask

  // One transfer: cycle 0 raises CHNL_RX; inputs change at negedge, outputs sampled 1 ns later.
  task automatic run_xfer(input vec_t v, input int seq);
    int beat = 0, sent = 0, ack_cnt = 0, ack_cyc = -1, last_cnt = 0, last_at = -1;
    int first_w = -1, last_w = -1, done_cyc = -1, valid_cnt = 0, ren_cnt = 0;
    int data_bad = 0, hold_bad = 0, ren_bad = 0;
    bit rx_on = 1'b1, acked = 1'b0, done_seen = 1'b0, done_abort = 1'b0, prev_stall = 1'b0;
    bit rdy;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    string t;
    t = $sformatf("x%0d", seq);

    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      @(negedge CLK);
      rdy = v.toggle ? (cyc % 2 == 0) : 1'b1;
      bus.CHNL_RX            = rx_on;
      bus.CHNL_RX_LEN        = v.len;
      bus.CHNL_RX_OFF        = v.off;
      bus.CHNL_RX_LAST       = v.seq_last;
      bus.CHNL_RX_DATA_VALID = acked && (beat < v.beats);
      bus.CHNL_RX_DATA       = beat_data(seq, beat);
      bus.WORD_READY         = rdy;
      #1;
      if (bus.CHNL_RX_ACK) begin
        ack_cnt++;
        ack_cyc = cyc;
      end
      if (bus.CHNL_RX_DATA_REN) begin
        ren_cnt++;
        if (bus.WORD_VALID && !(rdy && (sent % W == W - 1) && !bus.WORD_LAST)) ren_bad++;
        if (beat * W >= int'(v.len)) ren_bad++;
        if (bus.CHNL_RX_DATA_VALID) beat++;
      end
      if (bus.WORD_VALID) begin
        valid_cnt++;
        if (prev_stall && (bus.WORD_DATA !== prev_data || bus.WORD_LAST !== prev_last)) hold_bad++;
        prev_stall = !rdy;
        prev_data  = bus.WORD_DATA;
        prev_last  = bus.WORD_LAST;
        if (rdy) begin
          if (bus.WORD_DATA !== beat_word(seq, sent / W, sent % W)) data_bad++;
          if (bus.WORD_LAST) begin
            last_cnt++;
            last_at = sent;
          end
          if (first_w < 0) first_w = cyc;
          last_w = cyc;
          sent++;
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (bus.XFER_DONE) begin
        done_seen  = 1'b1;
        done_abort = bus.XFER_ABORT;
        done_cyc   = cyc;
      end
      if (ack_cnt > 0) acked = 1'b1;
      if (acked && beat >= v.beats) rx_on = 1'b0;
    end

    check({t, "_done_seen"}, done_seen, 1'b1);
    if (done_seen) begin
      check({t, "_ack_cnt"}, ack_cnt, 1);
      check({t, "_ack_cyc"}, ack_cyc, 1);
      check({t, "_words"}, sent, v.exp_words);
      check({t, "_data_bad"}, data_bad, 0);
      check({t, "_hold_bad"}, hold_bad, 0);
      check({t, "_ren_bad"}, ren_bad, 0);
      check({t, "_last_cnt"}, last_cnt, v.exp_abort ? 0 : (v.exp_words > 0 ? 1 : 0));
      if (last_cnt == 1) check({t, "_last_at"}, last_at, v.exp_words - 1);
      check({t, "_abort"}, done_abort, v.exp_abort);
      if (v.exp_done >= 0) check({t, "_done_cyc"}, done_cyc, v.exp_done);
      if (!v.toggle && v.exp_words > 0) check({t, "_no_bubble"}, last_w - first_w, v.exp_words - 1);
      if (v.exp_words == 0) begin
        check({t, "_no_valid"}, valid_cnt, 0);
        check({t, "_no_ren"}, ren_cnt, 0);
      end
      check({t, "_xlen"}, bus.XFER_LEN, v.len);
      check({t, "_xoff"}, bus.XFER_OFF, v.off);
      check({t, "_xseql"}, bus.XFER_SEQ_LAST, v.seq_last);

      tot_words += v.exp_words;
      if (!v.exp_abort) tot_xfers++;
      @(negedge CLK);
      #1;
      check({t, "_done_pulse"}, bus.XFER_DONE, 1'b0);
      check({t, "_stat_xfers"}, bus.STAT_XFERS, STATS ? tot_xfers : 0);
      check({t, "_stat_words"}, bus.STAT_WORDS, STATS ? tot_words : 0);
    end
    bus.CHNL_RX            = 1'b0;
    bus.CHNL_RX_DATA_VALID = 1'b0;
  endtask

  // Park a beat in the buffer with READY low, then reset in the middle of the transfer.
  task automatic reset_mid_recv();
    int n;
    @(negedge CLK);
    bus.CHNL_RX     = 1'b1;
    bus.CHNL_RX_LEN = 32'd8;
    bus.CHNL_RX_OFF = 31'h155;
    bus.WORD_READY  = 1'b0;
    n = 0;
    while (!bus.CHNL_RX_ACK && n < 20) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check("rst_wait_ack", bus.CHNL_RX_ACK, 1'b1);
    @(negedge CLK);
    bus.CHNL_RX_DATA_VALID = 1'b1;
    bus.CHNL_RX_DATA       = beat_data(9, 0);
    n = 0;
    #1;
    while (!bus.WORD_VALID && n < 20) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check("rst_wait_valid", bus.WORD_VALID, 1'b1);
    check("rst_buf_word0", bus.WORD_DATA, beat_word(9, 0, 0));
    bus.CHNL_RX_DATA_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    drive_idle();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    tot_xfers = 0;
    tot_words = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      #1;
      check($sformatf("rst_no_done%0d", i), bus.XFER_DONE, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        len    off      sl  beats tog words abort done
    tbl[0] = '{32'd8,  31'h10,  1'b0, 2, 1'b0, 8, 1'b0, 11};
    tbl[1] = '{32'd5,  31'h20,  1'b1, 2, 1'b0, 5, 1'b0, 8};
    tbl[2] = '{32'd8,  31'h30,  1'b0, 2, 1'b1, 8, 1'b0, -1};
    tbl[3] = '{32'd0,  31'h40,  1'b1, 0, 1'b0, 0, 1'b0, 2};
    tbl[4] = '{32'd12, 31'h50,  1'b0, 1, 1'b0, 4, 1'b1, 8};
    tbl[5] = '{32'd3,  31'h7FFF_FFFF, 1'b1, 1, 1'b1, 3, 1'b0, -1};
    tbl[6] = '{32'd4,  31'h60,  1'b1, 1, 1'b0, 4, 1'b0, 7};

    drive_idle();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    check_reset_outputs("por");
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 6; i++) begin
      run_xfer(tbl[i], i);
      repeat (2) @(negedge CLK);
    end

    reset_mid_recv();
    run_xfer(tbl[6], 7);
    repeat (2) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
